// File: rtl/cfm_cmd_fsm.sv
// cfm_cmd_fsm: host command sequencer moving packet RAM words to the flash controller and acking each command
module cfm_cmd_fsm #(
  parameter int NUMBER = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_rx,
  input  logic [7:0]  cmd_rx,
  input  logic [7:0]  len_rx,
  output logic        start_tx,
  output logic [7:0]  cmd_tx,
  output logic [7:0]  len_tx,
  output logic        start_rd_ram,
  input  logic        done_rd_ram,
  output logic [7:0]  start_rd_addr,
  input  logic [31:0] rd_word,
  output logic        start_wr_ram,
  input  logic        done_wr_ram,
  output logic [7:0]  start_wr_addr,
  output logic [31:0] wr_word,
  input  logic        done_getimg,
  output logic        start_addr,
  output logic [31:0] addr_data,
  output logic        start_wrdata,
  output logic [31:0] wr_data_data,
  input  logic [31:0] rd_data_data,
  input  logic        done_data,
  input  logic        done_csr
);
  typedef enum logic [2:0] {IDLE, DECODE, RD_REQ, RD_WAIT, ADDR_GO, WR_GO, WR_WAIT, ACK} state_t;
  state_t state, nxt;
  logic [7:0] cmd_q, len_q;
  logic [5:0] idx;
  logic is_addr, is_wr, more;
  logic unused_in;
  assign unused_in = ^{done_wr_ram, done_getimg, rd_data_data, done_csr, NUMBER};
  assign is_addr = cmd_q == 8'h41;
  assign is_wr = cmd_q == 8'h4B;
  assign more = {1'b0, idx} + 7'd1 < {1'b0, len_q[7:2]};
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start_rx ? DECODE : IDLE;
      DECODE:  nxt = (is_addr || (is_wr && len_q[7:2] != 6'd0)) ? RD_REQ : ACK;
      RD_REQ:  nxt = RD_WAIT;
      RD_WAIT: nxt = done_rd_ram ? (is_addr ? ADDR_GO : WR_GO) : RD_WAIT;
      ADDR_GO: nxt = ACK;
      WR_GO:   nxt = WR_WAIT;
      WR_WAIT: nxt = done_data ? (more ? RD_REQ : ACK) : WR_WAIT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cmd_q <= '0;
      len_q <= '0;
      idx <= '0;
      addr_data <= '0;
      wr_data_data <= '0;
      cmd_tx <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start_rx) begin
        cmd_q <= cmd_rx;
        len_q <= len_rx;
      end
      if (state == DECODE) idx <= '0;
      if (state == RD_WAIT && done_rd_ram) begin
        if (is_addr) addr_data <= rd_word;
        else wr_data_data <= rd_word;
      end
      if (state == WR_WAIT && done_data) begin
        addr_data <= addr_data + 32'd1;
        idx <= idx + 6'd1;
      end
      // cmd_tx must be valid in the same cycle as the start_tx pulse
      if (nxt == ACK) cmd_tx <= (is_addr || is_wr) ? cmd_q : 8'hEE;
    end
  end
  assign start_tx = state == ACK;
  assign len_tx = '0;
  assign start_rd_ram = state == RD_REQ;
  assign start_rd_addr = (state == RD_REQ || state == RD_WAIT) ? {idx, 2'b00} : '0;
  assign start_addr = state == ADDR_GO;
  assign start_wrdata = state == WR_GO;
  assign start_wr_ram = 1'b0;
  assign start_wr_addr = '0;
  assign wr_word = '0;
endmodule

// File: tb/tb_cfm_cmd_fsm.sv
// tb_cfm_cmd_fsm: directed and randomized command checks against a transaction-level reference model
module tb_cfm_cmd_fsm;
  logic clk = 0, reset = 1, start_rx = 0;
  logic [7:0] cmd_rx = 0, len_rx = 0;
  logic start_tx, start_rd_ram, start_wr_ram, start_addr, start_wrdata;
  logic [7:0] cmd_tx, len_tx, start_rd_addr, start_wr_addr;
  logic [31:0] wr_word, addr_data, wr_data_data;
  logic done_rd_ram = 0, done_data = 0;
  logic [31:0] rd_word = 0;
  logic [7:0] ram [256];
  int checks = 0, failures = 0, flash_lat = 5;
  logic [31:0] rd_q[$], addr_q[$], wr_q[$], ack_q[$], len_q[$];
  logic [31:0] addr_model = 0;

  cfm_cmd_fsm dut (
    .clk(clk), .reset(reset), .start_rx(start_rx), .cmd_rx(cmd_rx), .len_rx(len_rx),
    .start_tx(start_tx), .cmd_tx(cmd_tx), .len_tx(len_tx),
    .start_rd_ram(start_rd_ram), .done_rd_ram(done_rd_ram), .start_rd_addr(start_rd_addr), .rd_word(rd_word),
    .start_wr_ram(start_wr_ram), .done_wr_ram(1'b0), .start_wr_addr(start_wr_addr), .wr_word(wr_word),
    .done_getimg(1'b0), .start_addr(start_addr), .addr_data(addr_data), .start_wrdata(start_wrdata),
    .wr_data_data(wr_data_data), .rd_data_data(32'hDEAD_BEEF), .done_data(done_data), .done_csr(1'b0)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(int a);
    return {ram[a], ram[a+1], ram[a+2], ram[a+3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(negedge clk);
    if (start_rd_ram) rd_q.push_back({24'd0, start_rd_addr});
    if (start_addr) addr_q.push_back(addr_data);
    if (start_wrdata) wr_q.push_back(wr_data_data);
    if (start_tx) begin
      ack_q.push_back({24'd0, cmd_tx});
      len_q.push_back({24'd0, len_tx});
    end
  end

  initial forever begin
    @(negedge clk);
    if (start_rd_ram && !reset) begin
      automatic int a = start_rd_addr;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1 rd_word = word_at(a);
      done_rd_ram = 1;
      @(posedge clk);
      #1 done_rd_ram = 0;
      rd_word = $urandom;
    end
  end

  initial forever begin
    @(negedge clk);
    if (start_wrdata && !reset) begin
      repeat (flash_lat) @(posedge clk);
      #1 done_data = 1;
      @(posedge clk);
      #1 done_data = 0;
    end
  end

  task automatic clear_q();
    rd_q.delete(); addr_q.delete(); wr_q.delete(); ack_q.delete(); len_q.delete();
  endtask

  task automatic pulse_rx(input logic [7:0] c, input logic [7:0] l);
    start_rx = 1; cmd_rx = c; len_rx = l;
    step();
    start_rx = 0;
  endtask

  task automatic issue(input logic [7:0] c, input logic [7:0] l, input bit extra);
    int n = 0;
    clear_q();
    pulse_rx(c, l);
    if (extra) begin
      repeat (6) step();
      pulse_rx(8'h41, 8'd4);
    end
    while (ack_q.size() == 0 && n < 3000) begin
      step();
      n++;
    end
    chk("ack_seen", {31'd0, ack_q.size() != 0}, 32'd1);
    repeat (12) step();
  endtask

  task automatic expect_cmd(input string tag, input logic [7:0] c, input logic [7:0] l);
    int nr;
    nr = (c == 8'h41) ? 1 : (c == 8'h4B) ? int'(l) / 4 : 0;
    chk({tag, "_nreads"}, rd_q.size(), nr);
    for (int i = 0; i < nr && i < rd_q.size(); i++) chk({tag, "_rdaddr"}, rd_q[i], 4 * i);
    chk({tag, "_naddr"}, addr_q.size(), (c == 8'h41) ? 1 : 0);
    if (c == 8'h41) begin
      addr_model = word_at(0);
      if (addr_q.size() > 0) chk({tag, "_addrval"}, addr_q[0], addr_model);
    end
    chk({tag, "_nwr"}, wr_q.size(), (c == 8'h4B) ? nr : 0);
    if (c == 8'h4B) begin
      for (int i = 0; i < nr && i < wr_q.size(); i++) chk({tag, "_wrdata"}, wr_q[i], word_at(4 * i));
      addr_model = addr_model + nr;
    end
    chk({tag, "_addr_final"}, addr_data, addr_model);
    chk({tag, "_nack"}, ack_q.size(), 1);
    if (ack_q.size() > 0) begin
      chk({tag, "_ackcmd"}, ack_q[0], (c == 8'h41 || c == 8'h4B) ? {24'd0, c} : 32'hEE);
      chk({tag, "_acklen"}, len_q[0], 0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_start_tx"}, {31'd0, start_tx}, 0);
    chk({tag, "_cmd_tx"}, {24'd0, cmd_tx}, 0);
    chk({tag, "_len_tx"}, {24'd0, len_tx}, 0);
    chk({tag, "_start_rd_ram"}, {31'd0, start_rd_ram}, 0);
    chk({tag, "_start_rd_addr"}, {24'd0, start_rd_addr}, 0);
    chk({tag, "_start_wr_ram"}, {31'd0, start_wr_ram}, 0);
    chk({tag, "_start_wr_addr"}, {24'd0, start_wr_addr}, 0);
    chk({tag, "_wr_word"}, wr_word, 0);
    chk({tag, "_start_addr"}, {31'd0, start_addr}, 0);
    chk({tag, "_addr_data"}, addr_data, 0);
    chk({tag, "_start_wrdata"}, {31'd0, start_wrdata}, 0);
    chk({tag, "_wr_data_data"}, wr_data_data, 0);
  endtask

  initial begin
    int n;
    logic [7:0] c, l;
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    ram[0] = 8'h00; ram[1] = 8'hAC; ram[2] = 8'h00; ram[3] = 8'h10;
    repeat (2) step();
    chk_zero("reset");
    reset = 0;
    repeat (3) step();
    issue(8'h41, 8'd4, 0);
    expect_cmd("addr", 8'h41, 8'd4);
    chk("addr_value", addr_data, 32'h00AC0010);
    issue(8'h4B, 8'd16, 0);
    expect_cmd("wr16", 8'h4B, 8'd16);
    chk("wr16_final", addr_data, 32'h00AC0014);
    issue(8'h4B, 8'd0, 0);
    expect_cmd("wr0", 8'h4B, 8'd0);
    issue(8'h4B, 8'd3, 0);
    expect_cmd("wr3", 8'h4B, 8'd3);
    issue(8'h55, 8'd8, 0);
    expect_cmd("bad", 8'h55, 8'd8);
    issue(8'h4B, 8'd16, 1);
    expect_cmd("ignore_rx", 8'h4B, 8'd16);
    clear_q();
    pulse_rx(8'h4B, 8'd32);
    n = 0;
    while (wr_q.size() == 0 && n < 200) begin
      step();
      n++;
    end
    chk("rst_reach_wr", {31'd0, wr_q.size() != 0}, 1);
    step();
    reset = 1;
    repeat (2) step();
    chk_zero("midrst");
    reset = 0;
    addr_model = 0;
    repeat (12) step();
    chk("midrst_noack", ack_q.size(), 0);
    issue(8'h41, 8'd4, 0);
    expect_cmd("post_rst", 8'h41, 8'd4);
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    for (int k = 0; k < 20; k++) begin
      n = $urandom_range(0, 2);
      l = 8'($urandom);
      c = 8'($urandom);
      if (c == 8'h41 || c == 8'h4B) c = 8'h00;
      c = (n == 0) ? 8'h41 : (n == 1) ? 8'h4B : c;
      flash_lat = $urandom_range(1, 6);
      issue(c, l, 0);
      expect_cmd("rand", c, l);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
